// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer with unicast, broadcast and out-of-range drop.
// Each channel has a one-deep output register. Back-pressure stays local to its channel.
module demux_1ton_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SEL_W = $clog2(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_bcast,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [7:0]             drop_count
);

   localparam int unsigned CNT_W = 8;

   logic [N_OUT-1:0]       slot_free;
   logic [N_OUT-1:0]       sel_onehot;
   logic                   sel_in_range;
   logic                   accept;
   logic [N_OUT-1:0]       load;

   logic [N_OUT*WIDTH-1:0] out_data_d,   out_data_q;
   logic [N_OUT-1:0]       out_valid_d,  out_valid_q;
   logic [CNT_W-1:0]       drop_count_d, drop_count_q;

   // Slot freedom and destination decode. in_valid never reaches in_ready.
   always_comb begin
      slot_free    = ~out_valid_q | out_ready;
      sel_in_range = (32'(in_sel) < N_OUT);
      sel_onehot   = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         sel_onehot[k] = (32'(in_sel) == k);
      end
      if (in_bcast) begin
         in_ready = &slot_free;
      end else if (sel_in_range) begin
         in_ready = |(sel_onehot & slot_free);
      end else begin
         in_ready = 1'b1;
      end
   end

   // Next-state: loads win over drains; out-of-range beats only bump the counter.
   always_comb begin
      accept       = in_valid & in_ready;
      load         = '0;
      out_data_d   = out_data_q;
      drop_count_d = drop_count_q;
      if (accept) begin
         load = in_bcast ? {N_OUT{1'b1}} : sel_onehot;
      end
      out_valid_d = (out_valid_q & ~out_ready) | load;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if (load[k]) begin
            out_data_d[k*WIDTH +: WIDTH] = in_data;
         end
      end
      if (accept && !in_bcast && !sel_in_range && (drop_count_q != {CNT_W{1'b1}})) begin
         drop_count_d = drop_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_q   <= '0;
         out_valid_q  <= '0;
         drop_count_q <= '0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream: a 4-channel instance for routing/back-pressure
// and a 3-channel instance for out-of-range drops.
module tb_demux_1ton_stream;

   logic        clk;
   logic        rst;

   logic [7:0]  data4;
   logic [1:0]  sel4;
   logic        bcast4;
   logic        valid4;
   logic        ready4;
   logic [31:0] odata4;
   logic [3:0]  ovalid4;
   logic [3:0]  oready4;
   logic [7:0]  drop4;

   logic [7:0]  data3;
   logic [1:0]  sel3;
   logic        bcast3;
   logic        valid3;
   logic        ready3;
   logic [23:0] odata3;
   logic [2:0]  ovalid3;
   logic [2:0]  oready3;
   logic [7:0]  drop3;

   int n_cmp;
   int n_err;

   demux_1ton_stream #(.WIDTH(8), .N_OUT(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_data(data4), .in_sel(sel4), .in_bcast(bcast4),
      .in_valid(valid4), .in_ready(ready4), .out_data(odata4), .out_valid(ovalid4),
      .out_ready(oready4), .drop_count(drop4)
   );

   demux_1ton_stream #(.WIDTH(8), .N_OUT(3)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(data3), .in_sel(sel3), .in_bcast(bcast3),
      .in_valid(valid3), .in_ready(ready3), .out_data(odata3), .out_valid(ovalid3),
      .out_ready(oready3), .drop_count(drop3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational in_ready settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      data4  = 8'hFF; sel4 = 2'd0; bcast4 = 1'b0; valid4 = 1'b1; oready4 = 4'h0;
      data3  = 8'hEE; sel3 = 2'd3; bcast3 = 1'b0; valid3 = 1'b1; oready3 = 3'h0;

      // Reset held with a live beat: nothing loads, nothing drops.
      tick();
      tick();
      check_eq("rst_ovalid4", 32'(ovalid4), 32'h0);
      check_eq("rst_odata4",  odata4, 32'h0);
      check_eq("rst_drop4",   32'(drop4), 32'h0);
      check_eq("rst_ovalid3", 32'(ovalid3), 32'h0);
      check_eq("rst_drop3",   32'(drop3), 32'h0);
      check_eq("rst_ready4",  32'(ready4), 32'h1);
      rst = 1'b0; valid4 = 1'b0; valid3 = 1'b0;
      tick();

      // Unicast to channel 2, drained the following cycle.
      oready4 = 4'hF; sel4 = 2'd2; data4 = 8'hA5; valid4 = 1'b1;
      settle();
      check_eq("uni_ready", 32'(ready4), 32'h1);
      tick();
      check_eq("uni_ovalid", 32'(ovalid4), 32'h4);
      check_eq("uni_data2",  32'(odata4[23:16]), 32'hA5);
      valid4 = 1'b0;
      tick();
      check_eq("uni_drain", 32'(ovalid4), 32'h0);

      // Back-pressure on channel 1; channel 3 keeps flowing.
      oready4 = 4'b1101; sel4 = 2'd1; data4 = 8'h11; valid4 = 1'b1;
      tick();
      check_eq("bp_ovalid1", 32'(ovalid4), 32'h2);
      check_eq("bp_data1",   32'(odata4[15:8]), 32'h11);
      data4 = 8'h22;
      settle();
      check_eq("bp_ready_lo", 32'(ready4), 32'h0);
      tick();
      check_eq("bp_hold_data", 32'(odata4[15:8]), 32'h11);
      check_eq("bp_hold_vld",  32'(ovalid4), 32'h2);
      sel4 = 2'd3; data4 = 8'h33;
      settle();
      check_eq("bp_ch3_ready", 32'(ready4), 32'h1);
      tick();
      check_eq("bp_ch3_vld",  32'(ovalid4), 32'hA);
      check_eq("bp_ch3_data", 32'(odata4[31:24]), 32'h33);
      sel4 = 2'd1; data4 = 8'h22; oready4 = 4'hF;
      settle();
      check_eq("bp_refill_ready", 32'(ready4), 32'h1);
      tick();
      check_eq("bp_refill_data", 32'(odata4[15:8]), 32'h22);
      check_eq("bp_refill_vld",  32'(ovalid4), 32'h2);
      valid4 = 1'b0;
      tick();
      check_eq("bp_idle", 32'(ovalid4), 32'h0);

      // Broadcast, then a second broadcast blocked by a full channel 0.
      oready4 = 4'b1110; bcast4 = 1'b1; data4 = 8'h3C; valid4 = 1'b1;
      settle();
      check_eq("bc_ready", 32'(ready4), 32'h1);
      tick();
      check_eq("bc_ovalid", 32'(ovalid4), 32'hF);
      check_eq("bc_data",   odata4, 32'h3C3C3C3C);
      data4 = 8'h5A;
      settle();
      check_eq("bc_blocked", 32'(ready4), 32'h0);
      tick();
      check_eq("bc_part_vld", 32'(ovalid4), 32'h1);
      check_eq("bc_ch0_hold", 32'(odata4[7:0]), 32'h3C);
      check_eq("bc_still_blocked", 32'(ready4), 32'h0);
      oready4 = 4'hF;
      settle();
      check_eq("bc_unblocked", 32'(ready4), 32'h1);
      tick();
      check_eq("bc2_ovalid", 32'(ovalid4), 32'hF);
      check_eq("bc2_data",   odata4, 32'h5A5A5A5A);
      valid4 = 1'b0; bcast4 = 1'b0;
      tick();
      check_eq("bc_idle", 32'(ovalid4), 32'h0);

      // Out-of-range select on the 3-channel instance: drops saturate at 255.
      oready3 = 3'h7; sel3 = 2'd3; data3 = 8'h99; valid3 = 1'b1;
      settle();
      check_eq("oor_ready", 32'(ready3), 32'h1);
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 10)  check_eq("oor_drop10",  32'(drop3), 32'd10);
         if (i == 255) check_eq("oor_drop255", 32'(drop3), 32'd255);
      end
      check_eq("oor_sat",    32'(drop3), 32'd255);
      check_eq("oor_ovalid", 32'(ovalid3), 32'h0);
      check_eq("oor_ready2", 32'(ready3), 32'h1);
      sel3 = 2'd2; data3 = 8'h77;
      tick();
      check_eq("inr_ovalid", 32'(ovalid3), 32'h4);
      check_eq("inr_data",   32'(odata3[23:16]), 32'h77);
      check_eq("inr_drop",   32'(drop3), 32'd255);
      valid3 = 1'b0;
      check_eq("drop4_zero", 32'(drop4), 32'h0);

      // Full-rate streaming over rotating selects, then reset mid-stream.
      oready4 = 4'hF; valid4 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [1:0] s;
         logic [7:0] d;
         s = 2'(i % 4);
         d = 8'(8'h40 + i);
         sel4 = s; data4 = d;
         settle();
         check_eq("str_ready", 32'(ready4), 32'h1);
         tick();
         check_eq("str_ovalid", 32'(ovalid4), 32'(4'b0001 << s));
         check_eq("str_data",   32'(odata4[s*8 +: 8]), 32'(d));
      end
      rst = 1'b1;
      tick();
      check_eq("midrst_ovalid", 32'(ovalid4), 32'h0);
      check_eq("midrst_odata",  odata4, 32'h0);
      rst = 1'b0; valid4 = 1'b0;
      tick();
      check_eq("post_rst_idle", 32'(ovalid4), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
